grf_write_arbiter: RTL and testbench
====================================

# grf_write_arbiter

Shares the single GRF write port between two writeback sources: port 0 is the main pipeline W-stage result, port 1 is the long-latency unit (multiply/divide) result. Port 0 has fixed priority. A wait counter bounds port 1 starvation. The winning request is registered and presented one cycle later on the GRF write inputs (RegWrite/A3/WD/pc).

## Interface
- MAX_WAIT, 4, max consecutive cycles a nonzero-address port 1 request may be refused before it is forced through (legal range ≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- p0_valid  in  1  port 0 write request
- p0_ready  out  1  port 0 accept (transfer = valid & ready)
- p0_addr  in  5  port 0 destination register
- p0_data  in  32  port 0 write data
- p0_pc  in  32  port 0 instruction PC (trace)
- p1_valid / p1_ready / p1_addr / p1_data / p1_pc  in/out/in/in/in  1/1/5/32/32  port 1, same meaning
- grf_we  out  1  to GRF RegWrite
- grf_a3  out  5  to GRF A3
- grf_wd  out  32  to GRF WD
- grf_pc  out  32  to GRF pc
- force_active  out  1  high while in state FORCE

## Operation
- States: NORMAL, FORCE. Counter cnt, width clog2(MAX_WAIT+1).
- A request is "real" when valid=1 and addr≠0. A request with addr=0 is always ready. It is accepted and discarded: no grant, no counter effect.
- Handshake rule for requesters: once valid is asserted, hold valid and keep the payload stable until the transfer occurs.
- p0_ready = (state==NORMAL) | (p0_addr==0).
- p1_ready = (p1_addr==0) | (state==FORCE) | !(p0_valid & p0_addr≠0).
- grant0 = real p0 & state==NORMAL.
- grant1 = real p1 & p1_ready.
- At most one grant per cycle.
- Counter and state:
  - In NORMAL, when p1 is real and refused, cnt += 1. When cnt reaches MAX_WAIT, the next state is FORCE and cnt is held.
  - In NORMAL, grant1 clears cnt to 0.
  - In NORMAL, a cycle with no real p1 clears cnt to 0.
  - FORCE always lasts exactly one cycle. The next state is NORMAL and cnt = 0, whether or not p1 was granted.
  - In FORCE, p0 is stalled.
  - If p1_valid dropped in FORCE (protocol violation), there is no grant that cycle, but p0 is still stalled.
- Output register, on posedge:
  - On a grant: grf_we←1 and grf_a3/grf_wd/grf_pc←the winner's addr/data/pc.
  - With no grant: grf_we←0; grf_a3/wd/pc hold.
- Same nonzero addr on both ports in one cycle: port 0 writes first and port 1 writes in a later cycle. The final register value is port 1's.

## Timing
- Reset (asynchronous, active-low): state NORMAL, cnt 0, grf_we 0, grf_a3 0, grf_wd 0, grf_pc 0, force_active 0.
  - Asserting reset mid-operation immediately drops any registered write (grf_we→0).
  - Requests are ignored while reset is low.
- Latency: a transfer in cycle N produces grf_we=1 with its payload during cycle N+1. The GRF commits the write at the end of cycle N+1, via its own write-to-read bypass.
- p0_ready and p1_ready are combinational from valid/addr/state, with no dependency on the outputs.
- Throughput: one real write per cycle. Back-to-back grants produce continuous grf_we=1.
- Starvation bound: with p0 real every cycle, a real p1 is refused for exactly MAX_WAIT cycles and granted in the (MAX_WAIT+1)th cycle. Port 0 loses that single cycle.
- force_active = (state==FORCE), combinational from state.

## Test plan
- Reset then idle: release reset with no valid → grf_we=0, grf_a3=0, force_active=0 for 10 cycles. Assert reset low mid-write → grf_we falls without waiting for a clock edge.
- Single port 0: p0 addr=5, data=0x1234, pc=0x3000 in cycle N → p0_ready=1 in N. In N+1: grf_we=1, a3=5, wd=0x1234, pc=0x3000. In N+2: grf_we=0.
- Contention, MAX_WAIT=4: p0 real every cycle (addr 8) and p1 addr=9, data=0xBEEF asserted at cycle 0.
  - p1_ready=0 in cycles 0–3.
  - Cycle 4: force_active=1, p1_ready=1, p0_ready=0.
  - Cycle 5: grf_a3=9, wd=0xBEEF.
  - Cycle 5: p0 resumes, and cnt restarts only for a new p1 request.
- Same address: p0 and p1 both addr=3 (data 0x11 and 0x22) in cycle N, p0 then idle → writes a3=3 wd=0x11 in N+1, then a3=3 wd=0x22 in N+2.
- Zero register: p0 addr=0 and p1 addr=0 valid together → both readies=1 and grf_we stays 0. Then p0 addr=0 with p1 addr=7 → p1 granted the same cycle.
- Withdrawn request: p1 waits until FORCE, then drops valid in FORCE → no write next cycle, p0_ready=0 in that cycle only, state NORMAL afterward.

Source files
------------

// File: rtl/grf_write_arbiter.sv
// Two-source arbiter for the single GRF write port: port 0 has fixed priority, and a wait counter bounds port 1 starvation.
// The winning write is registered and appears on grf_* one cycle after the transfer.
module grf_write_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [4:0]  p0_addr,
  input  logic [31:0] p0_data,
  input  logic [31:0] p0_pc,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [4:0]  p1_addr,
  input  logic [31:0] p1_data,
  input  logic [31:0] p1_pc,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  output logic        force_active
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        grf_we_q;
  logic [4:0]  grf_a3_q;
  logic [31:0] grf_wd_q;
  logic [31:0] grf_pc_q;

  logic p0_real, p1_real, grant0, grant1;

  // Writes to r0 are accepted and discarded, so they never compete.
  assign p0_real = p0_valid & (p0_addr != 5'd0);
  assign p1_real = p1_valid & (p1_addr != 5'd0);

  assign p0_ready = (state_q == NORMAL) | (p0_addr == 5'd0);
  assign p1_ready = (p1_addr == 5'd0) | (state_q == FORCE) | ~p0_real;

  assign grant0 = p0_real & (state_q == NORMAL);
  assign grant1 = p1_real & p1_ready;

  assign force_active = (state_q == FORCE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == FORCE) begin
      state_d = NORMAL;
      cnt_d   = '0;
    end else if (p1_real && !grant1) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == CW'(MAX_WAIT)) begin
        state_d = FORCE;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload holds when idle; only the write enable drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we_q <= 1'b0;
      grf_a3_q <= '0;
      grf_wd_q <= '0;
      grf_pc_q <= '0;
    end else begin
      grf_we_q <= grant0 | grant1;
      if (grant0) begin
        grf_a3_q <= p0_addr;
        grf_wd_q <= p0_data;
        grf_pc_q <= p0_pc;
      end else if (grant1) begin
        grf_a3_q <= p1_addr;
        grf_wd_q <= p1_data;
        grf_pc_q <= p1_pc;
      end
    end
  end

  assign grf_we = grf_we_q;
  assign grf_a3 = grf_a3_q;
  assign grf_wd = grf_wd_q;
  assign grf_pc = grf_pc_q;

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Bench for grf_write_arbiter: directed scenarios plus constrained-random traffic against a cycle-level reference model.
module tb_grf_write_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        reset;
  logic        p0_valid, p0_ready, p1_valid, p1_ready;
  logic [4:0]  p0_addr, p1_addr;
  logic [31:0] p0_data, p0_pc, p1_data, p1_pc;
  logic        grf_we, force_active;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;

  grf_write_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data), .p0_pc(p0_pc),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data), .p1_pc(p1_pc),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .force_active(force_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: how long the current port 1 request has been refused,
  // whether this is the forced cycle, and the expected registered write.
  int          m_streak;
  bit          m_force;
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd, m_pc;

  // Values sampled at the falling edge of the last cycle, for directed checks.
  logic        s_p0r, s_p1r, s_fa, s_we;
  logic [4:0]  s_a3;
  logic [31:0] s_wd, s_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_streak = 0; m_force = 0; m_we = 0; m_a3 = '0; m_wd = '0; m_pc = '0;
  endtask

  task automatic drive0(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    p0_valid = v; p0_addr = a; p0_data = d; p0_pc = pc;
  endtask

  task automatic drive1(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    p1_valid = v; p1_addr = a; p1_data = d; p1_pc = pc;
  endtask

  // One clock: check everything against the model mid-cycle, advance the model
  // at the rising edge, and return just after it so the caller can drive inputs.
  task automatic cycle();
    bit p0_real, p1_real, e_p0r, e_p1r;
    @(negedge clk);
    p0_real = p0_valid && (p0_addr != 0);
    p1_real = p1_valid && (p1_addr != 0);
    e_p0r = !m_force || (p0_addr == 0);
    e_p1r = (p1_addr == 0) || m_force || !p0_real;
    s_p0r = p0_ready; s_p1r = p1_ready; s_fa = force_active;
    s_we = grf_we; s_a3 = grf_a3; s_wd = grf_wd; s_pc = grf_pc;
    chk("p0_ready", 32'(p0_ready), 32'(e_p0r));
    chk("p1_ready", 32'(p1_ready), 32'(e_p1r));
    chk("force_active", 32'(force_active), 32'(m_force));
    chk("grf_we", 32'(grf_we), 32'(m_we));
    chk("grf_a3", 32'(grf_a3), 32'(m_a3));
    chk("grf_wd", grf_wd, m_wd);
    chk("grf_pc", grf_pc, m_pc);
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      if (p0_real && !m_force) begin
        m_we = 1; m_a3 = p0_addr; m_wd = p0_data; m_pc = p0_pc;
      end else if (p1_real && e_p1r) begin
        m_we = 1; m_a3 = p1_addr; m_wd = p1_data; m_pc = p1_pc;
      end else begin
        m_we = 0;
      end
      if (m_force) begin
        m_force = 0; m_streak = 0;
      end else if (p1_real && !e_p1r) begin
        m_streak++;
        if (m_streak == MAX_WAIT) m_force = 1;
      end else begin
        m_streak = 0;
      end
    end
    #1;
  endtask

  initial begin
    bit hold0, hold1;
    reset = 1'b0;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    model_reset();
    repeat (2) cycle();
    reset = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle_we", 32'(s_we), 0);
      chk("idle_a3", 32'(s_a3), 0);
      chk("idle_fa", 32'(s_fa), 0);
    end

    // Single port 0 write.
    drive0(1, 5'd5, 32'h1234, 32'h3000);
    cycle();
    chk("single_p0_ready", 32'(s_p0r), 1);
    drive0(0, 0, 0, 0);
    cycle();
    chk("single_we", 32'(s_we), 1);
    chk("single_a3", 32'(s_a3), 5);
    chk("single_wd", s_wd, 32'h1234);
    chk("single_pc", s_pc, 32'h3000);
    cycle();
    chk("single_we_off", 32'(s_we), 0);

    // Contention: p0 real every cycle, p1 forced through after MAX_WAIT refusals.
    for (int i = 0; i < 8; i++) begin
      drive0(1, 5'd8, 32'hA000 + i, 32'h4000 + 4 * i);
      if (i == 0) drive1(1, 5'd9, 32'hBEEF, 32'h5000);
      cycle();
      if (i < MAX_WAIT) chk("cont_p1_refused", 32'(s_p1r), 0);
      if (i == MAX_WAIT) begin
        chk("cont_force", 32'(s_fa), 1);
        chk("cont_p1_ready", 32'(s_p1r), 1);
        chk("cont_p0_stall", 32'(s_p0r), 0);
        drive1(0, 0, 0, 0);
      end
      if (i == MAX_WAIT + 1) begin
        chk("cont_a3", 32'(s_a3), 9);
        chk("cont_wd", s_wd, 32'hBEEF);
        chk("cont_p0_resume", 32'(s_p0r), 1);
        chk("cont_fa_off", 32'(s_fa), 0);
      end
    end
    drive0(0, 0, 0, 0);
    cycle();

    // Same destination on both ports: port 0 first, port 1 next.
    drive0(1, 5'd3, 32'h11, 32'h100);
    drive1(1, 5'd3, 32'h22, 32'h200);
    cycle();
    drive0(0, 0, 0, 0);
    cycle();
    chk("same_a3_1", 32'(s_a3), 3);
    chk("same_wd_1", s_wd, 32'h11);
    drive1(0, 0, 0, 0);
    cycle();
    chk("same_a3_2", 32'(s_a3), 3);
    chk("same_wd_2", s_wd, 32'h22);

    // Zero register on both ports, then r0 on p0 with a real p1.
    drive0(1, 5'd0, 32'hDEAD, 32'h1);
    drive1(1, 5'd0, 32'hCAFE, 32'h2);
    cycle();
    chk("zero_p0r", 32'(s_p0r), 1);
    chk("zero_p1r", 32'(s_p1r), 1);
    drive1(1, 5'd7, 32'h77, 32'h700);
    cycle();
    chk("zero_we", 32'(s_we), 0);
    chk("zero_p1_grant", 32'(s_p1r), 1);
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    cycle();
    chk("zero_p1_we", 32'(s_we), 1);
    chk("zero_p1_a3", 32'(s_a3), 7);

    // Withdrawn request during the forced cycle.
    for (int i = 0; i < 7; i++) begin
      drive0(1, 5'd8, 32'hC000 + i, 32'h6000);
      drive1(i < MAX_WAIT, 5'd9, 32'hF00D, 32'h7000);
      cycle();
      if (i == MAX_WAIT) begin
        chk("wd_force", 32'(s_fa), 1);
        chk("wd_p0_stall", 32'(s_p0r), 0);
      end
      if (i == MAX_WAIT + 1) begin
        chk("wd_no_write", 32'(s_we), 0);
        chk("wd_normal", 32'(s_fa), 0);
        chk("wd_p0_ready", 32'(s_p0r), 1);
      end
      if (i == MAX_WAIT + 2) chk("wd_p0_write", 32'(s_a3), 8);
    end

    // Asynchronous reset while a write is being presented.
    drive1(0, 0, 0, 0);
    drive0(1, 5'd12, 32'h5555, 32'h8000);
    cycle();
    chk("pre_rst_we", 32'(grf_we), 1);
    #2 reset = 1'b0;
    #1 chk("async_rst_we", 32'(grf_we), 0);
    model_reset();
    repeat (2) begin
      cycle();
      chk("rst_ignore_we", 32'(s_we), 0);
    end
    drive0(0, 0, 0, 0);
    reset = 1'b1;
    cycle();

    // Random traffic honouring the hold-until-transfer rule.
    hold0 = 0;
    hold1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold0) begin
        drive0($urandom_range(0, 3) != 0, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom, $urandom);
      end
      if (!hold1) begin
        drive1($urandom_range(0, 2) != 0, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom, $urandom);
      end
      cycle();
      hold0 = p0_valid && !s_p0r;
      hold1 = p1_valid && !s_p1r;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
